demux32_8_reg: RTL

//  Registered 1-to-N demultiplexer, the write-side counterpart of the datapath read muxes.
//  It takes one result word with a destination select and commits it into one of NUM_OUT holding registers.

---
 rtl/demux32_8_reg_if.sv | 28 ++
 rtl/demux32_8_reg.sv | 108 ++++++++++
 2 files changed

// File: rtl/demux32_8_reg_if.sv
// Result-bus interface between the write-side demux and its source/destinations.
interface demux32_8_reg_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned SEL_W   = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           in_sel;
    logic [WIDTH-1:0]           in_data;
    logic [NUM_OUT-1:0]         dst_busy;
    logic [NUM_OUT*WIDTH-1:0]   dst_q;
    logic [NUM_OUT-1:0]         dst_wr;
    logic                       pend;
    logic                       sel_err;

    // Source side: drives the word, select and destination busy flags
    modport master (
        output in_valid, in_sel, in_data, dst_busy,
        input  in_ready, dst_q, dst_wr, pend, sel_err
    );

    // Demux side
    modport slave (
        input  in_valid, in_sel, in_data, dst_busy,
        output in_ready, dst_q, dst_wr, pend, sel_err
    );
endinterface

// File: rtl/demux32_8_reg.sv
// Registered 1-to-NUM_OUT write demux: commits one result word into a holding
// register per transfer, stalling while the selected destination is busy.
module demux32_8_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned SEL_W   = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    demux32_8_reg_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nx;

    logic [SEL_W-1:0]           pend_sel;
    logic [WIDTH-1:0]           pend_data;

    logic [NUM_OUT*WIDTH-1:0]   dst_q;
    logic [NUM_OUT-1:0]         dst_wr;
    logic                       pend;
    logic                       sel_err;

    logic                       in_range_c;
    logic                       commit_c;
    logic                       capture_c;
    logic                       bad_sel_c;
    logic [SEL_W-1:0]           wr_sel_c;
    logic [WIDTH-1:0]           wr_data_c;

    // Out-of-range selects must never index dst_busy or the register file
    assign in_range_c = (32'(bus.in_sel) < NUM_OUT);

    // Next-state and commit decode; buffered word takes priority in PEND
    always_comb begin
        state_nx  = state;
        commit_c  = 1'b0;
        capture_c = 1'b0;
        bad_sel_c = 1'b0;
        wr_sel_c  = bus.in_sel;
        wr_data_c = bus.in_data;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!in_range_c) begin
                        bad_sel_c = 1'b1;
                    end else if (bus.dst_busy[bus.in_sel]) begin
                        capture_c = 1'b1;
                        state_nx  = PEND;
                    end else begin
                        commit_c  = 1'b1;
                    end
                end
            end
            PEND: begin
                wr_sel_c  = pend_sel;
                wr_data_c = pend_data;
                if (!bus.dst_busy[pend_sel]) begin
                    commit_c = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pending buffer, holding registers and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pend_sel  <= '0;
            pend_data <= '0;
            dst_q     <= '0;
            dst_wr    <= '0;
            pend      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state  <= state_nx;
            pend   <= (state_nx == PEND);
            dst_wr <= commit_c ? (NUM_OUT'(1) << wr_sel_c) : '0;
            if (capture_c) begin
                pend_sel  <= bus.in_sel;
                pend_data <= bus.in_data;
            end
            if (bad_sel_c) begin
                sel_err <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (commit_c && (wr_sel_c == SEL_W'(i))) begin
                    dst_q[i*WIDTH +: WIDTH] <= wr_data_c;
                end
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.dst_q    = dst_q;
    assign bus.dst_wr   = dst_wr;
    assign bus.pend     = pend;
    assign bus.sel_err  = sel_err;

endmodule
